// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-Lite encodings and the FSM state type for the SRAM slave.
package ahb_sram_slave_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} state_t;

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite signal bundle between the bus fabric (master side) and the SRAM slave.
interface ahb_sram_slave_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  // Handshake: an address phase is taken when HSEL & HREADY & HTRANS[1] at a rising
  // edge; a data phase completes at the first edge where HREADYOUT (and so HREADY) is 1.
  logic              HSEL;
  logic [ADDR_W-1:0] HADDR;
  logic              HWRITE;
  logic [1:0]        HTRANS;
  logic [2:0]        HSIZE;
  logic              HREADY;
  logic [DATA_W-1:0] HWDATA;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADYOUT;
  logic              HRESP;

  modport master (
    output HSEL, HADDR, HWRITE, HTRANS, HSIZE, HREADY, HWDATA,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HWRITE, HTRANS, HSIZE, HREADY, HWDATA,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_sram_slave_bytemem.sv
// Byte-writable word memory with one registered read port; a read that lands on the
// same edge as a write to the same word sees the newly written lanes.
module ahb_sram_bytemem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W/8-1:0]        we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       re,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_W-1:0]          rdata
);
  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (we[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      for (int b = 0; b < NB; b++) begin
        rdata[8*b +: 8] <= (we[b] && (waddr == raddr)) ? wdata[8*b +: 8] : mem[raddr][8*b +: 8];
      end
    end
  end
endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: pipelined address/data phases, fixed wait states,
// sub-word writes by HSIZE and a two-cycle ERROR response.
module ahb_sram_slave
  import ahb_sram_slave_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic             HCLK,
  input  logic             HRESET,
  ahb_sram_slave_if.slave  bus,
  output state_t           dbg_state
);
  localparam int         NB    = DATA_W / 8;
  localparam int         LB    = $clog2(NB);
  localparam int         IDX_W = $clog2(DEPTH);
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  state_t            state;
  logic [3:0]        cnt;
  logic              ready_q, resp_q;
  logic [IDX_W-1:0]  cap_idx;
  logic [LB-1:0]     cap_off;
  logic [2:0]        cap_size;
  logic              cap_write;

  logic [ADDR_W-1:0] word_addr;
  logic [IDX_W-1:0]  addr_idx;
  logic              accept, addr_valid, addr_err, misaligned;
  logic              rd_addr_phase, rd_final, wr_commit;
  logic [NB-1:0]     be;
  int                be_lo, be_hi;
  logic [DATA_W-1:0] rdata;

  assign word_addr = bus.HADDR >> LB;
  assign addr_idx  = word_addr[IDX_W-1:0];

  // Offset bits below the transfer size must all be zero.
  always_comb begin
    misaligned = 1'b0;
    for (int b = 0; b < LB; b++) begin
      if (bus.HADDR[b] && (b < int'(bus.HSIZE))) misaligned = 1'b1;
    end
  end

  assign accept     = (state == ST_IDLE) || (state == ST_ERR2) ||
                      ((state == ST_DATA) && (cnt == 4'd0));
  assign addr_valid = accept && bus.HSEL && bus.HREADY &&
                      ((bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ));
  assign addr_err   = (word_addr >= ADDR_W'(DEPTH)) || (int'(bus.HSIZE) > LB) || misaligned;

  // With no wait states the read is launched straight from the address phase.
  assign rd_addr_phase = addr_valid && !addr_err && !bus.HWRITE && (WS == 4'd0);
  assign rd_final      = (state == ST_DATA) && (cnt == 4'd1) && !cap_write;
  assign wr_commit     = (state == ST_DATA) && (cnt == 4'd0) && cap_write;

  always_comb begin
    be_lo = int'(cap_off);
    be_hi = be_lo + (1 << cap_size);
    be    = '0;
    for (int b = 0; b < NB; b++) begin
      be[b] = wr_commit && (b >= be_lo) && (b < be_hi);
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      ready_q   <= 1'b1;
      resp_q    <= HRESP_OKAY;
      cap_idx   <= '0;
      cap_off   <= '0;
      cap_size  <= 3'd0;
      cap_write <= 1'b0;
    end else if (state == ST_ERR1) begin
      state   <= ST_ERR2;
      ready_q <= 1'b1;
      resp_q  <= HRESP_ERROR;
    end else if ((state == ST_DATA) && (cnt != 4'd0)) begin
      cnt     <= cnt - 4'd1;
      ready_q <= (cnt == 4'd1);
      resp_q  <= HRESP_OKAY;
    end else if (addr_valid && addr_err) begin
      state   <= ST_ERR1;
      ready_q <= 1'b0;
      resp_q  <= HRESP_ERROR;
    end else if (addr_valid) begin
      state     <= ST_DATA;
      cnt       <= WS;
      ready_q   <= (WS == 4'd0);
      resp_q    <= HRESP_OKAY;
      cap_idx   <= addr_idx;
      cap_off   <= bus.HADDR[LB-1:0];
      cap_size  <= bus.HSIZE;
      cap_write <= bus.HWRITE;
    end else begin
      state   <= ST_IDLE;
      ready_q <= 1'b1;
      resp_q  <= HRESP_OKAY;
    end
  end

  ahb_sram_bytemem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (HCLK),
    .rst   (HRESET),
    .we    (be),
    .waddr (cap_idx),
    .wdata (bus.HWDATA),
    .re    (rd_addr_phase || rd_final),
    .raddr (rd_final ? cap_idx : addr_idx),
    .rdata (rdata)
  );

  assign bus.HRDATA    = rdata;
  assign bus.HREADYOUT = ready_q;
  assign bus.HRESP     = resp_q;
  assign dbg_state     = state;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: three instances (0, 3 and 2 wait states), each the only
// slave on its own bus so HREADY is its own HREADYOUT.
module tb_ahb_sram_slave;
  import ahb_sram_slave_pkg::*;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_resp;
    int          exp_waits;
  } vec_t;

  logic        clk;
  logic        rst     [3];
  logic        sel     [3];
  logic [31:0] addr    [3];
  logic        write   [3];
  logic [1:0]  trans   [3];
  logic [2:0]  size    [3];
  logic [31:0] wdata   [3];
  logic [31:0] rdata_o [3];
  logic        ready_o [3];
  logic        resp_o  [3];
  state_t      dbg     [3];

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] ref_mem [3][256];
  logic [31:0] last_rd [3];
  vec_t        vecs    [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ahb_sram_slave_if #(.DATA_W(32), .ADDR_W(32)) bus ();
    assign bus.HSEL    = sel[g];
    assign bus.HADDR   = addr[g];
    assign bus.HWRITE  = write[g];
    assign bus.HTRANS  = trans[g];
    assign bus.HSIZE   = size[g];
    assign bus.HWDATA  = wdata[g];
    assign bus.HREADY  = bus.HREADYOUT;
    assign rdata_o[g]  = bus.HRDATA;
    assign ready_o[g]  = bus.HREADYOUT;
    assign resp_o[g]   = bus.HRESP;
    ahb_sram_slave #(
      .DATA_W(32), .ADDR_W(32), .DEPTH(256),
      .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 3 : 2))
    ) dut (
      .HCLK(clk), .HRESET(rst[g]), .bus(bus.slave), .dbg_state(dbg[g])
    );
  end

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 3 : 2);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input int k, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                       input logic [1:0] tr);
    sel[k] = 1'b1; write[k] = wr; addr[k] = a; size[k] = sz; trans[k] = tr;
  endtask

  task automatic idle(input int k);
    sel[k] = 1'b0; trans[k] = HTRANS_IDLE;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One isolated transfer; returns data/response seen in the completing data cycle.
  task automatic xfer(input int k, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd, output logic rs,
                      output int waits);
    drive(k, wr, a, sz, HTRANS_NONSEQ);
    tick();
    idle(k);
    wdata[k] = wd;
    waits = 0;
    while (!ready_o[k] && waits < 40) begin
      tick();
      waits++;
    end
    rd = rdata_o[k];
    rs = resp_o[k];
    tick();
  endtask

  task automatic add_vec(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                         input logic [31:0] wd, input logic [31:0] er, input bit ers,
                         input int ew);
    vec_t v;
    v.wr = wr; v.addr = a; v.size = sz; v.wdata = wd;
    v.exp_rd = er; v.exp_resp = ers; v.exp_waits = ew;
    vecs.push_back(v);
  endtask

  // Transfer checked against the reference memory model.
  task automatic xfer_model(input int k, input bit wr, input logic [31:0] a,
                            input logic [2:0] sz, input logic [31:0] wd, input string tag);
    logic [31:0] rd, exp_rd;
    logic        rs;
    int          waits, widx, nbytes, off;
    bit          err;
    nbytes = 1 << sz;
    err    = ((a >> 2) >= 256) || (sz > 3'd2) || ((a % nbytes) != 0);
    widx   = int'((a >> 2) & 32'hFF);
    off    = int'(a % 4);
    exp_rd = (!err && !wr) ? ref_mem[k][widx] : last_rd[k];
    xfer(k, wr, a, sz, wd, rd, rs, waits);
    chk({tag, " rdata"}, rd, exp_rd);
    chk({tag, " resp"}, 32'(rs), 32'(err));
    chk({tag, " waits"}, waits, err ? 1 : ws_of(k));
    chk({tag, " idle_after"}, {30'd0, ready_o[k], resp_o[k]}, 32'd2);
    if (!err && !wr) last_rd[k] = exp_rd;
    if (!err && wr) begin
      for (int i = off; i < off + nbytes; i++) ref_mem[k][widx][8*i +: 8] = wd[8*i +: 8];
    end
  endtask

  // Write whose data phase overlaps the address phase of a read of the same word.
  task automatic hazard(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd,
                        input logic [31:0] exp, input string nm);
    drive(0, 1'b1, a, sz, HTRANS_NONSEQ);
    tick();
    drive(0, 1'b0, a & ~32'h3, 3'd2, HTRANS_NONSEQ);
    wdata[0] = wd;
    chk({nm, " wr_ready"}, 32'(ready_o[0]), 32'd1);
    tick();
    idle(0);
    chk({nm, " rdata"}, rdata_o[0], exp);
    chk({nm, " resp"}, 32'(resp_o[0]), 32'd0);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        rs;
    int          waits, n;

    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; idle(k); addr[k] = '0; write[k] = 1'b0; size[k] = 3'd2; wdata[k] = '0;
      last_rd[k] = '0;
    end
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset%0d ready", k), 32'(ready_o[k]), 32'd1);
      chk($sformatf("reset%0d resp", k), 32'(resp_o[k]), 32'd0);
      chk($sformatf("reset%0d rdata", k), rdata_o[k], 32'd0);
      chk($sformatf("reset%0d state", k), 32'(dbg[k]), 32'(ST_IDLE));
      rst[k] = 1'b0;
    end
    tick();

    add_vec(1, 32'h000, 3'd2, 32'h01020304, 32'h00000000, 0, 0);
    add_vec(1, 32'h010, 3'd2, 32'hDEADBEEF, 32'h00000000, 0, 0);
    add_vec(0, 32'h010, 3'd2, 32'h0,        32'hDEADBEEF, 0, 0);
    add_vec(1, 32'h020, 3'd2, 32'h11223344, 32'hDEADBEEF, 0, 0);
    add_vec(1, 32'h021, 3'd0, 32'h0000AA00, 32'hDEADBEEF, 0, 0);
    add_vec(0, 32'h020, 3'd2, 32'h0,        32'h1122AA44, 0, 0);
    add_vec(1, 32'h400, 3'd2, 32'hFFFFFFFF, 32'h1122AA44, 1, 1);
    add_vec(0, 32'h400, 3'd2, 32'h0,        32'h1122AA44, 1, 1);
    add_vec(1, 32'h003, 3'd1, 32'hFFFF0000, 32'h1122AA44, 1, 1);
    add_vec(0, 32'h020, 3'd3, 32'h0,        32'h1122AA44, 1, 1);
    add_vec(0, 32'h000, 3'd2, 32'h0,        32'h01020304, 0, 0);
    add_vec(1, 32'h022, 3'd1, 32'hBEEF0000, 32'h01020304, 0, 0);
    add_vec(0, 32'h020, 3'd0, 32'h0,        32'hBEEFAA44, 0, 0);
    add_vec(1, 32'h3FC, 3'd2, 32'h0BADF00D, 32'hBEEFAA44, 0, 0);
    add_vec(0, 32'h3FC, 3'd2, 32'h0,        32'h0BADF00D, 0, 0);
    add_vec(0, 32'h012, 3'd1, 32'h0,        32'hDEADBEEF, 0, 0);
    add_vec(1, 32'h011, 3'd1, 32'h00FF0000, 32'hDEADBEEF, 1, 1);
    add_vec(0, 32'h010, 3'd2, 32'h0,        32'hDEADBEEF, 0, 0);

    foreach (vecs[i]) begin
      xfer(0, vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata, rd, rs, waits);
      chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d resp", i), 32'(rs), 32'(vecs[i].exp_resp));
      chk($sformatf("vec%0d waits", i), waits, vecs[i].exp_waits);
      chk($sformatf("vec%0d idle_after", i), {30'd0, ready_o[0], resp_o[0]}, 32'd2);
    end

    drive(0, 1'b0, 32'h010, 3'd2, HTRANS_BUSY);
    tick();
    chk("busy ready", 32'(ready_o[0]), 32'd1);
    chk("busy state", 32'(dbg[0]), 32'(ST_IDLE));
    idle(0);
    tick();

    hazard(32'h008, 3'd2, 32'h00000005, 32'h00000005, "hazard_word");
    xfer(0, 1'b1, 32'h00C, 3'd2, 32'hAABBCCDD, rd, rs, waits);
    hazard(32'h00C, 3'd0, 32'h00000077, 32'hAABBCC77, "hazard_byte");
    xfer(0, 1'b0, 32'h00C, 3'd2, 32'h0, rd, rs, waits);
    chk("hazard_byte commit", rd, 32'hAABBCC77);

    rst[0] = 1'b1;
    #2;
    chk("async_reset rdata", rdata_o[0], 32'd0);
    chk("async_reset ready", 32'(ready_o[0]), 32'd1);
    chk("async_reset resp", 32'(resp_o[0]), 32'd0);
    tick();
    rst[0] = 1'b0;
    last_rd[0] = '0;
    tick();

    drive(1, 1'b1, 32'h040, 3'd2, HTRANS_NONSEQ);
    tick();
    drive(1, 1'b0, 32'h040, 3'd2, HTRANS_SEQ);
    wdata[1] = 32'h12345678;
    n = 0;
    while (!ready_o[1] && n < 40) begin tick(); n++; end
    chk("seq wr waits", n, 3);
    tick();
    idle(1);
    n = 0;
    while (!ready_o[1] && n < 40) begin tick(); n++; end
    chk("seq rd waits", n, 3);
    chk("seq rd rdata", rdata_o[1], 32'h12345678);
    chk("seq rd resp", 32'(resp_o[1]), 32'd0);
    tick();
    last_rd[1] = 32'h12345678;

    xfer_model(2, 1'b1, 32'h030, 3'd2, 32'hCAFEF00D, "abort_pre");
    drive(2, 1'b1, 32'h030, 3'd2, HTRANS_NONSEQ);
    tick();
    idle(2);
    wdata[2] = 32'h0BADBEEF;
    chk("abort wait ready", 32'(ready_o[2]), 32'd0);
    tick();
    rst[2] = 1'b1;
    #1;
    chk("abort reset ready", 32'(ready_o[2]), 32'd1);
    chk("abort reset rdata", rdata_o[2], 32'd0);
    tick();
    rst[2] = 1'b0;
    last_rd[2] = '0;
    repeat (2) tick();
    xfer_model(2, 1'b0, 32'h030, 3'd2, 32'h0, "abort_post");

    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 16; w++) begin
        xfer_model(k, 1'b1, 32'h200 + 32'(4 * w), 3'd2, $urandom, $sformatf("pre%0d_%0d", k, w));
      end
      for (int i = 0; i < 60; i++) begin
        int          r;
        logic [31:0] a;
        logic [2:0]  sz;
        r  = $urandom_range(0, 9);
        sz = 3'($urandom_range(0, 2));
        a  = 32'h200 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
        if (r == 0) a = a + 32'h00000400 * 32'($urandom_range(1, 8));
        if (r == 1) sz = 3'd3;
        xfer_model(k, 1'($urandom_range(0, 1)), a, sz, $urandom, $sformatf("rnd%0d_%0d", k, i));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- Parametrised AHB-Lite memory slave; successor to the single-cycle fixed-size slave.
- Adds proper address/data phase pipelining, configurable wait states, byte/halfword writes via HSIZE, and two-cycle ERROR responses.
- Sits behind the address decoder on the shared AHB bus. HSEL comes from the decoder; HREADY is the bus-level ready fed back from the slave multiplexer.

Parameters:
- DATA_W, 32, data bus width in bits; must be 32 or 64.
- ADDR_W, 32, HADDR width.
- DEPTH, 256, number of DATA_W-bit words; word index = HADDR >> log2(DATA_W/8).
- WAIT_STATES, 0, HREADYOUT-low cycles inserted in every OKAY data phase; range 0..15.

Ports:
- HCLK  in  1  bus clock, all logic on rising edge
- HRESET  in  1  asynchronous, active-high reset
- HSEL  in  1  slave select from decoder
- HADDR  in  ADDR_W  address (address phase)
- HWRITE  in  1  1=write, 0=read (address phase)
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HSIZE  in  3  transfer size, 000=byte ... 011=doubleword
- HREADY  in  1  bus ready; an address phase is accepted only when high
- HWDATA  in  DATA_W  write data (data phase)
- HRDATA  out  DATA_W  read data
- HREADYOUT  out  1  this slave's ready
- HRESP  out  1  0=OKAY, 1=ERROR

Behaviour:
- Clock and reset: one clock, HCLK. HRESET is asynchronous and active-high.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=ST_IDLE, wait counter=0. Memory contents are not reset.
- Reset mid-transfer: a pending write is discarded and any wait/error sequence is aborted.
- Valid address phase: HSEL & HREADY & HTRANS[1]. IDLE/BUSY (or HSEL=0) gets a zero-wait OKAY response; no access.
- Address-phase capture: on a valid phase, register the word index, byte offset, HSIZE and HWRITE.
- Error check, done in the address phase. The transfer errors if any of:
  - word index >= DEPTH
  - HSIZE > log2(DATA_W/8)
  - address misaligned for HSIZE
- FSM states:
  - ST_IDLE: HREADYOUT=1, HRESP=0.
  - ST_DATA: wait counter loaded with WAIT_STATES. HREADYOUT=(cnt==0); cnt decrements while nonzero; HRESP=0.
  - ST_ERR1: HREADYOUT=0, HRESP=1.
  - ST_ERR2: HREADYOUT=1, HRESP=1.
- FSM transitions:
  - ST_ERR1 always goes to ST_ERR2.
  - From ST_IDLE, ST_DATA final cycle (cnt==0) or ST_ERR2: next state = ST_DATA on a valid OKAY address phase, ST_ERR1 on an erroring one, else ST_IDLE.
  - Back-to-back transfers therefore overlap address phase N+1 with the final data-phase cycle of N.
- Write timing:
  - HWDATA is sampled only in the final data-phase cycle (HREADYOUT=1).
  - Only the byte lanes selected by HSIZE and the offset are written.
  - The write commits at the edge that ends the data phase.
- Errored transfers write nothing and leave HRDATA unchanged.
- Read latency:
  - Memory is read at the edge that enters the final data-phase cycle. For WAIT_STATES=0 this is the address-phase edge; otherwise it is the edge where cnt reaches 0.
  - HRDATA is valid while HREADYOUT=1 and holds until the next read completes.
  - Full DATA_W word is returned regardless of HSIZE.
- Read-after-write hazard: if a read's memory-read edge coincides with a write commit to the same word, HRDATA returns the merged data (written lanes new, others old).
- HSEL deasserted while a data phase is pending does not cancel it.

Decomposition:
- ahb_pkg: HTRANS codes, HSIZE codes, HRESP codes (OKAY/ERROR), FSM state enum.
- Sub-module ahb_sram_bytemem: DEPTH x DATA_W array with per-byte write enables and one synchronous read port. Write-to-read forwarding lives in this sub-module.
- The FSM, error check and lane decode stay in the top.

Test Plan:
- Reset / single write-read, WAIT_STATES=0: write 0xDEADBEEF to 0x10, read 0x10 -> HRDATA=0xDEADBEEF; zero wait, HRESP=0. Assert HRESET -> HREADYOUT=1, HRESP=0, HRDATA=0 immediately.
- Byte lanes: write word 0x11223344 at 0x20, then byte 0xAA at 0x21 (HSIZE=000), then read 0x20 -> 0x1122AA44 (little-endian lanes).
- Wait states, WAIT_STATES=3: NONSEQ read -> HREADYOUT low exactly 3 cycles, then high with valid data. Back-to-back SEQ write+read to the same word -> read returns the new value.
- Out of range, DEPTH=256: access 0x400 -> HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1; memory and HRDATA unchanged; next IDLE cycle HRESP=0.
- Misaligned: halfword at 0x03 -> ERROR two-cycle response. HSIZE=011 with DATA_W=32 -> ERROR.
- Hazard and reset abort:
  - Write 0x5 to 0x8 with the next cycle's read of 0x8 overlapping -> HRDATA=0x5.
  - With WAIT_STATES=2, assert HRESET during a write wait -> the location keeps its old value.
